// File: rtl/zinterp_pkg.sv
// Shared constants and types for the per-phrase Z interpolator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the 16.16 accumulator geometry, the lane width, where each pixel
// lane lives inside srczplo/srczphi, and the output-slot state encoding.
package zinterp_pkg;

  localparam int ZW     = 32;  // accumulator / increment width, 16.16
  localparam int ZFRAC  = 16;  // fraction bits
  localparam int LANES  = 4;   // 16-bit pixel lanes per 64-bit phrase
  localparam int LANE_W = 16;  // integer Z width per lane

  // Lanes 0/1 are packed into srczplo, lanes 2/3 into srczphi,
  // lower-numbered lane in the low half of each word.
  localparam int LO_LANE0_LSB = 0;
  localparam int LO_LANE1_LSB = 16;
  localparam int HI_LANE2_LSB = 0;
  localparam int HI_LANE3_LSB = 16;

  // Output slot: EMPTY means out_valid=0, FULL means out_valid=1.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } zslot_t;

  // Pixels actually emitted: request count clamped to 4, then clipped so
  // that nothing spills past lane 3.
  function automatic logic [2:0] eff_npix(input logic [2:0] npix,
                                          input logic [1:0] lane0);
    logic [2:0] n;
    logic [2:0] room;
    n    = (npix > 3'd4) ? 3'd4 : npix;
    room = 3'd4 - {1'b0, lane0};
    return (n < room) ? n : room;
  endfunction

endpackage

// File: rtl/zlane_add.sv
// Adds a selected multiple of the Z increment to a base value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
//
// Ports:
//   base      in  accumulator value the lane or advance starts from
//   inc1..3   in  precomputed 1x/2x/3x increments
//   sel       in  multiple to add: 0..3, 4 selects 4x (inc2 shifted left)
//   sum       out base + sel*inc, wrapping mod 2^ZW
module zlane_add
  import zinterp_pkg::*;
(
  input  logic [ZW-1:0] base,
  input  logic [ZW-1:0] inc1,
  input  logic [ZW-1:0] inc2,
  input  logic [ZW-1:0] inc3,
  input  logic [2:0]    sel,
  output logic [ZW-1:0] sum
);

  logic [ZW-1:0] addend;

  always_comb begin
    addend = '0;
    case (sel)
      3'd0:    addend = '0;
      3'd1:    addend = inc1;
      3'd2:    addend = inc2;
      3'd3:    addend = inc3;
      default: addend = {inc2[ZW-2:0], 1'b0};  // 4x; only used by the advance path
    endcase
  end

  assign sum = base + addend;

endmodule

// File: rtl/zinterp_phrase.sv
// Per-phrase Z interpolator: emits integer Z for the four pixel lanes of a phrase.
// Latency: one cycle from accepted request to registered srczplo/srczphi/zmask.
// Backpressure: single output slot; holds while out_valid & !out_ready, req_ready low meanwhile.
//
// Ports:
//   sys_clk, reset            clock, asynchronous active-high reset
//   zload, zstart, zinc       load start Z and per-pixel increment (16.16)
//   req, req_ready            phrase request handshake
//   req_lane0, req_npix       first active lane, pixel count (5-7 act as 4)
//   out_valid, out_ready      output handshake
//   srczplo, srczphi, zmask   packed lane Z values and real-pixel mask
//   zcur                      accumulator after the last accepted request
module zinterp_phrase #(
  parameter int ZW    = 32,
  parameter int ZFRAC = 16,
  parameter int LANES = 4
) (
  input  logic          sys_clk,
  input  logic          reset,
  input  logic          zload,
  input  logic [ZW-1:0] zstart,
  input  logic [ZW-1:0] zinc,
  input  logic          req,
  output logic          req_ready,
  input  logic [1:0]    req_lane0,
  input  logic [2:0]    req_npix,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] srczplo,
  output logic [ZW-1:0] srczphi,
  output logic [LANES-1:0] zmask,
  output logic [ZW-1:0] zcur
);

  import zinterp_pkg::*;

  logic [ZW-1:0] acc;
  logic [ZW-1:0] inc1;
  logic [ZW-1:0] inc2;
  logic [ZW-1:0] inc3;
  logic [ZW-1:0] acc_next;
  zslot_t        slot_q;
  zslot_t        slot_d;

  logic [2:0]        neff;
  logic              accept;
  logic [LANE_W-1:0] lane_z [LANES];
  logic [LANES-1:0]  mask_c;
  logic [ZW-1:0]     lo_c;
  logic [ZW-1:0]     hi_c;

  assign neff      = eff_npix(req_npix, req_lane0);
  assign out_valid = (slot_q == ST_FULL);
  assign req_ready = !reset && !zload && (!out_valid || out_ready);
  assign accept    = req && req_ready;
  assign zcur      = acc;

  // Each lane is the accumulator plus its distance from the first active
  // lane times the increment; inactive lanes read as zero.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [2:0]    d;
    logic          on;
    logic [ZW-1:0] lane_sum;
    logic          unused_frac;

    assign d  = 3'(k) - {1'b0, req_lane0};  // wraps for lanes before lane0, gated by 'on'
    assign on = ({1'b0, req_lane0} <= 3'(k)) && (d < neff);

    zlane_add u_lane (
      .base (acc),
      .inc1 (inc1),
      .inc2 (inc2),
      .inc3 (inc3),
      .sel  (on ? d : 3'd0),
      .sum  (lane_sum)
    );

    // Fraction bits matter only to the accumulator advance path.
    assign unused_frac = &{1'b0, lane_sum[ZFRAC-1:0]};
    assign lane_z[k]   = on ? lane_sum[ZW-1:ZFRAC] : '0;
    assign mask_c[k]   = on;
  end

  always_comb begin
    lo_c = '0;
    hi_c = '0;
    lo_c[LO_LANE0_LSB +: LANE_W] = lane_z[0];
    lo_c[LO_LANE1_LSB +: LANE_W] = lane_z[1];
    hi_c[HI_LANE2_LSB +: LANE_W] = lane_z[2];
    hi_c[HI_LANE3_LSB +: LANE_W] = lane_z[3];
  end

  // Accumulator advances by the number of pixels actually emitted.
  zlane_add u_adv (
    .base (acc),
    .inc1 (inc1),
    .inc2 (inc2),
    .inc3 (inc3),
    .sel  (neff),
    .sum  (acc_next)
  );

  // Output slot: zload flushes a pending phrase, accept fills the slot,
  // out_ready without a new accept drains it.
  always_comb begin
    slot_d = slot_q;
    if (zload) begin
      slot_d = ST_EMPTY;
    end else if (accept) begin
      slot_d = ST_FULL;
    end else if (out_ready) begin
      slot_d = ST_EMPTY;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      slot_q <= ST_EMPTY;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      inc1    <= '0;
      inc2    <= '0;
      inc3    <= '0;
      srczplo <= '0;
      srczphi <= '0;
      zmask   <= '0;
    end else if (zload) begin
      acc  <= zstart;
      inc1 <= zinc;
      inc2 <= {zinc[ZW-2:0], 1'b0};
      inc3 <= {zinc[ZW-2:0], 1'b0} + zinc;
    end else if (accept) begin
      acc     <= acc_next;
      srczplo <= lo_c;
      srczphi <= hi_c;
      zmask   <= mask_c;
    end
  end

endmodule
